// File: rtl/prog_seq_detector_pkg.sv
// rtl/prog_seq_detector_pkg.sv - shared mode encoding and reset-default constants
// Purpose: mode encoding and default pattern/length used by the detector
//          and its parameter defaults.
package prog_seq_detector_pkg;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

  // Wide enough for the largest supported pattern; the top slices it to PAT_W.
  localparam logic [31:0] DEF_PATTERN_C = 32'h0000_000B;
  localparam int unsigned DEF_LEN_C     = 4;
  localparam bit          DEF_OVERLAP_C = 1'b1;

endpackage

// File: rtl/prog_seq_detector_sat_counter.sv
// rtl/prog_seq_detector_sat_counter.sv - saturating event counter
// Purpose: counts inc pulses, holds at all-ones, clr has priority over inc.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   inc         count one event this cycle
//   clr         synchronous clear to zero (wins over inc)
//   count_o     current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prog_seq_detector.sv
// rtl/prog_seq_detector.sv - programmable serial pattern detector
// Purpose: detects a runtime-loadable bit pattern of 1..PAT_W bits in a
//          qualified serial stream, overlapping or non-overlapping, and
//          counts matches with a saturating counter.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   x, x_valid   serial data bit and its qualifier
//   cfg_load     one-cycle strobe loading cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  pattern, bit [len-1] received first, bit 0 last
//   cfg_len      pattern length (0 disables, >PAT_W clamps to PAT_W)
//   cfg_overlap  1 = overlapping, 0 = non-overlapping
//   clr_count    synchronous clear of match_count
//   z            registered match flag, high the cycle after a match
//   match_count  saturating match count
module prog_seq_detector
  import prog_seq_detector_pkg::*;
#(
  parameter int unsigned      PAT_W       = 8,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [PAT_W-1:0] DEF_PATTERN = DEF_PATTERN_C[PAT_W-1:0],
  parameter int unsigned      DEF_LEN     = DEF_LEN_C,
  parameter bit               DEF_OVERLAP = DEF_OVERLAP_C
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       x,
  input  logic                       x_valid,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       clr_count,
  output logic                       z,
  output logic [CNT_W-1:0]           match_count
);

  localparam int unsigned      LEN_W     = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] DEF_LEN_L = (DEF_LEN > PAT_W) ? PAT_W_L : LEN_W'(DEF_LEN);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  mode_e            mode_q, mode_d;
  logic             z_q, z_d;

  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] shifted;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] len_mask;

  always_comb begin
    // A load cycle owns the datapath; any sample presented with it is dropped.
    accept   = x_valid & ~cfg_load;
    shifted  = {hist_q[PAT_W-2:0], x};
    fill_inc = (fill_q == PAT_W_L) ? PAT_W_L : fill_q + 1'b1;

    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    // Fill count includes the bit being accepted, so compare against the
    // shifted history rather than the stored one.
    hit = accept && (len_q != '0) && (fill_inc >= len_q) &&
          (((shifted ^ pat_q) & len_mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    mode_d = mode_q;
    z_d    = 1'b0;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > PAT_W_L) ? PAT_W_L : cfg_len;
      mode_d = mode_e'(cfg_overlap);
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = shifted;
      // Non-overlapping mode forgets the matched bits by emptying the fill
      // count; the stale history is harmless because fill gates the compare.
      fill_d = (hit && (mode_q == NON_OVERLAP)) ? '0 : fill_inc;
      z_d    = hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= DEF_LEN_L;
      mode_q <= mode_e'(DEF_OVERLAP);
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      z_q    <= z_d;
    end
  end

  assign z = z_q;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (hit),
    .clr    (clr_count),
    .count_o(match_count)
  );

endmodule

// File: tb/tb_prog_seq_detector.sv
// tb/tb_prog_seq_detector.sv - self-checking bench for prog_seq_detector
module tb_prog_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       x, x_valid, cfg_load, cfg_overlap, clr_count;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       z, z2;
  logic [15:0] match_count;
  logic [1:0]  match_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prog_seq_detector dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .z(z), .match_count(match_count)
  );

  prog_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .z(z2), .match_count(match_count2)
  );

  // Reference model: list of accepted bits since the last load/clear.
  bit         hq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_z;
  int         m_cnt, m_cnt2;

  function automatic void model_reset();
    hq.delete();
    m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
    m_z = 1'b0; m_cnt = 0; m_cnt2 = 0;
  endfunction

  function automatic void model_step(logic ld, logic [7:0] pat, logic [3:0] len,
                                     logic ovl, logic v, logic xb, logic clr);
    bit match = 1'b0;
    if (ld) begin
      m_pat = pat;
      m_len = (int'(len) > 8) ? 8 : int'(len);
      m_ovl = ovl;
      hq.delete();
    end else if (v) begin
      hq.push_back(xb);
      if (hq.size() > 8) void'(hq.pop_front());
      if (m_len > 0 && hq.size() >= m_len) begin
        match = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (hq[hq.size() - 1 - i] != m_pat[i]) match = 1'b0;
      end
      if (match && !m_ovl) hq.delete();
    end
    m_z = match;
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (match) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic v, input logic xb, input logic clr);
    cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    x_valid = v; x = xb; clr_count = clr;
    @(posedge clk);
    #1;
    model_step(ld, pat, len, ovl, v, xb, clr);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       v;
    logic       xb;
    logic       clr;
    logic       ez;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic ld, logic [7:0] pat, logic [3:0] len, logic ovl,
                              logic v, logic xb, logic clr, logic ez, int ecnt);
    vec_t r;
    r.ld = ld; r.pat = pat; r.len = len; r.ovl = ovl; r.v = v; r.xb = xb;
    r.clr = clr; r.ez = ez; r.ecnt = ecnt;
    tbl.push_back(r);
  endfunction

  function automatic void addb(logic xb, logic ez, int ecnt);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb, 1'b0, ez, ecnt);
  endfunction

  function automatic void addbubble(int ecnt);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ecnt);
  endfunction

  initial begin
    bit s1 [10];
    bit zo [10];
    bit zn [10];
    int co [10];
    int cn [10];
    s1 = '{1,0,1,1,0,1,1,0,1,1};
    zo = '{0,0,0,1,0,0,1,0,0,1};
    co = '{0,0,0,1,1,1,2,2,2,3};
    zn = '{0,0,0,1,0,0,0,0,0,1};
    cn = '{0,0,0,1,1,1,1,1,1,2};

    // Default config, overlapping
    for (int i = 0; i < 10; i++) addb(s1[i], zo[i], co[i]);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    // Non-overlapping reload; the x on the load cycle must be dropped
    add(1'b1, 8'h0B, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) addb(s1[i], zn[i], cn[i]);
    // Back to 1011 overlapping, with clear; then bubbled stream
    add(1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    addb(1'b1, 1'b0, 0); addbubble(0);
    addb(1'b0, 1'b0, 0); addbubble(0);
    addb(1'b1, 1'b0, 0); addbubble(0);
    addb(1'b1, 1'b1, 1); addbubble(1); addbubble(1);
    // Length 15 clamps to 8
    add(1'b1, 8'hFF, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 7; i++) addb(1'b1, 1'b0, 1);
    addb(1'b1, 1'b1, 2);
    addb(1'b1, 1'b1, 3);
    // Length 0 disables detection
    add(1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++) addb(1'b0, 1'b0, 3);
    // Clear coinciding with a match wins
    add(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    addb(1'b1, 1'b1, 1);

    cfg_load = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    x = 0; x_valid = 0; clr_count = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_z", {31'd0, z}, 32'd0);
    check("reset_cnt", {16'd0, match_count}, 32'd0);
    check("reset_cnt2", {30'd0, match_count2}, 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].v, tbl[i].xb, tbl[i].clr);
      check($sformatf("tbl_z[%0d]", i), {31'd0, z}, {31'd0, tbl[i].ez});
      check($sformatf("tbl_cnt[%0d]", i), {16'd0, match_count}, tbl[i].ecnt);
    end

    // Pattern 11, len 2, overlapping: three consecutive z cycles
    drive(1'b1, 8'h03, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("ovl11_z[%0d]", i), {31'd0, z}, (i == 0) ? 32'd0 : 32'd1);
    end
    check("ovl11_cnt", {16'd0, match_count}, 32'd3);

    // Asynchronous reset mid-sequence
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    model_reset();
    check("async_rst_cnt", {16'd0, match_count}, 32'd0);
    check("async_rst_z", {31'd0, z}, 32'd0);
    reset = 1'b0;
    begin
      bit rs [5];
      bit rz [5];
      rs = '{1,1,0,1,1};
      rz = '{0,0,0,0,1};
      for (int i = 0; i < 5; i++) begin
        drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, rs[i], 1'b0);
        check($sformatf("post_rst_z[%0d]", i), {31'd0, z}, {31'd0, rz[i]});
      end
      check("post_rst_cnt", {16'd0, match_count}, 32'd1);
    end

    // Saturation in the 2-bit counter, then clear on a match
    drive(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("sat_cnt2[%0d]", i), {30'd0, match_count2}, (i < 3) ? i + 1 : 3);
    end
    check("sat_cnt16", {16'd0, match_count}, 32'd5);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("sat_clr_z", {31'd0, z2}, 32'd1);
    check("sat_clr_cnt2", {30'd0, match_count2}, 32'd0);
    check("sat_clr_cnt16", {16'd0, match_count}, 32'd0);

    // Randomized stream against the model
    for (int i = 0; i < 400; i++) begin
      logic       ld, ovl, v, xb, clr;
      logic [7:0] pat;
      logic [3:0] len;
      ld  = ($urandom_range(0, 99) < 4);
      pat = 8'($urandom);
      len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      ovl = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      xb  = 1'($urandom);
      clr = ($urandom_range(0, 99) < 3);
      drive(ld, pat, len, ovl, v, xb, clr);
      check($sformatf("rnd_z[%0d]", i), {31'd0, z}, {31'd0, m_z});
      check($sformatf("rnd_cnt[%0d]", i), {16'd0, match_count}, m_cnt);
      check($sformatf("rnd_cnt2[%0d]", i), {30'd0, match_count2}, m_cnt2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
